// File: rtl/fir_output_sink.sv
// fir_output_sink: consumes the FIR accumulator stream, optionally decimates,
// rescales to sample width with round-half-up and saturation, and buffers the
// results in a show-ahead FIFO drained over a valid/ready handshake.
module fir_output_sink #(
  parameter int N3    = 32,
  parameter int N2    = 16,
  parameter int SHIFT = 7,
  parameter int DECIM = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     RST_N,
  input  logic [N3-1:0]            in_data,
  input  logic                     in_valid,
  input  logic                     clear_flags,
  output logic [N2-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sat,
  output logic                     overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [N3:0] RND  = (SHIFT > 0) ? ((N3+1)'(1) << RSH) : '0;
  localparam logic signed [N3:0] MAXV = ((N3+1)'(1) << (N2 - 1)) - (N3+1)'(1);
  localparam logic signed [N3:0] MINV = -MAXV - (N3+1)'(1);

  localparam logic [CW-1:0] DLAST = CW'(DECIM - 1);
  localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

  logic [CW-1:0]        dcnt;
  logic                 keep;

  logic signed [N3:0]   ext;
  logic signed [N3:0]   rsum;
  logic signed [N3:0]   rshift;
  logic                 clip_hi;
  logic                 clip_lo;
  logic [N2-1:0]        scaled;

  logic [N2-1:0]        s1_data;
  logic                 s1_valid;

  logic [N2-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign keep = in_valid && (dcnt == '0);

  // Rescale in one extra bit so the rounding offset cannot wrap, then clip.
  always_comb begin
    ext     = {in_data[N3-1], in_data};
    rsum    = ext + RND;
    rshift  = rsum >>> SHIFT;
    clip_hi = rshift > MAXV;
    clip_lo = rshift < MINV;
    scaled  = rshift[N2-1:0];
    if (clip_hi) scaled = MAXV[N2-1:0];
    else if (clip_lo) scaled = MINV[N2-1:0];
  end

  // Decimation counter advances only on valid input words.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      dcnt <= '0;
    end else if (in_valid) begin
      if (dcnt == DLAST) dcnt <= '0;
      else dcnt <= dcnt + CW'(1);
    end
  end

  // Stage 1: register the scaled sample of each kept word.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_data <= scaled;
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == FULLC);
  assign do_pop    = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the reader takes the head.
  assign do_push   = s1_valid && (!full || do_pop);
  assign out_data  = mem[rd_ptr];

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status flags; a new set event wins over a clear.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (keep && (clip_hi || clip_lo)) sat <= 1'b1;
      else if (clear_flags) sat <= 1'b0;
      if (s1_valid && full && !do_pop) overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_output_sink.sv
// Scoreboard bench for fir_output_sink: one instance with DECIM=1, one with
// DECIM=4. Expected samples are queued at issue; a monitor checks pops.
module tb_fir_output_sink;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;

  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0;
  logic        a_clear = 1'b0;
  logic [15:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [3:0]  a_count;
  logic        a_sat;
  logic        a_overflow;

  logic [31:0] b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_clear = 1'b0;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [3:0]  b_count;
  logic        b_sat;
  logic        b_overflow;

  int tests = 0;
  int fails = 0;
  int qa[$];
  int qb[$];
  int ea, eb;

  always #5 clk = ~clk;

  fir_output_sink #(.N3(32), .N2(16), .SHIFT(7), .DECIM(1), .DEPTH(8)) dut_a (
    .clk(clk), .RST_N(RST_N), .in_data(a_in_data), .in_valid(a_in_valid),
    .clear_flags(a_clear), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .count(a_count), .sat(a_sat), .overflow(a_overflow));

  fir_output_sink #(.N3(32), .N2(16), .SHIFT(7), .DECIM(4), .DEPTH(8)) dut_b (
    .clk(clk), .RST_N(RST_N), .in_data(b_in_data), .in_valid(b_in_valid),
    .clear_flags(b_clear), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .count(b_count), .sat(b_sat), .overflow(b_overflow));

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  // Monitor: every accepted output word is compared against the scoreboard.
  always @(negedge clk) begin
    if (RST_N && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected: got %0d, required no output", $signed(a_out_data));
      end else begin
        ea = qa.pop_front();
        chk("a_data", int'($signed(a_out_data)), ea);
      end
    end
    if (RST_N && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got %0d, required no output", $signed(b_out_data));
      end else begin
        eb = qb.pop_front();
        chk("b_data", int'($signed(b_out_data)), eb);
      end
    end
  end

  task automatic send_a(input logic [31:0] val, input bit kept, input int exp);
    a_in_data  = val;
    a_in_valid = 1'b1;
    if (kept) qa.push_back(exp);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] val, input bit kept, input int exp);
    b_in_data  = val;
    b_in_valid = 1'b1;
    if (kept) qb.push_back(exp);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  // Issue one sample on A with the reader ready and check the 2-edge latency.
  task automatic send_a_lat(input logic [31:0] val, input int exp);
    send_a(val, 1'b1, exp);
    @(negedge clk);
    chk("a_lat_edge1_valid", int'(a_out_valid), 0);
    @(negedge clk);
    chk("a_lat_edge2_valid", int'(a_out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_a_valid", int'(a_out_valid), 0);
    chk("rst_a_count", int'(a_count), 0);
    chk("rst_a_data", int'(a_out_data), 0);
    chk("rst_b_count", int'(b_count), 0);
    @(negedge clk);
    #2 RST_N = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream
    for (int k = 1; k <= 5; k++) send_a(32'(128 * k), 1'b1, k);
    chk("t1_count_before", int'(a_count), 4);
    #2 RST_N = 1'b0;
    #1;
    chk("t1_valid", int'(a_out_valid), 0);
    chk("t1_count", int'(a_count), 0);
    chk("t1_data", int'(a_out_data), 0);
    chk("t1_sat", int'(a_sat), 0);
    chk("t1_ovf", int'(a_overflow), 0);
    qa.delete();
    @(negedge clk);
    #2 RST_N = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    send_a_lat(32'd256, 2);

    // Scaling and rounding
    send_a_lat(32'd128000, 1000);
    send_a_lat(32'd64, 1);
    send_a_lat(32'd63, 0);
    send_a_lat(-32'sd64, 0);
    send_a_lat(-32'sd65, -1);
    chk("t2_sat", int'(a_sat), 0);

    // Saturation and sticky flag
    send_a(32'h7FFF_FFFF, 1'b1, 32767);
    @(negedge clk);
    chk("t3_sat_set", int'(a_sat), 1);
    @(posedge clk);
    #1;
    send_a(32'h8000_0000, 1'b1, -32768);
    a_clear = 1'b1;
    @(posedge clk);
    #1 a_clear = 1'b0;
    chk("t3_sat_cleared", int'(a_sat), 0);
    a_clear = 1'b1;
    send_a(32'h7FFF_FFFF, 1'b1, 32767);
    a_clear = 1'b0;
    chk("t3_set_wins", int'(a_sat), 1);
    a_clear = 1'b1;
    @(posedge clk);
    #1 a_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Decimation on B: consecutive, then with gaps
    for (int k = 0; k < 8; k++) send_b(32'(128 * k), (k % 4) == 0, k);
    for (int k = 0; k < 8; k++) begin
      send_b(32'(128 * (10 + k)), (k % 4) == 0, 10 + k);
      repeat (k % 3) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("t4_b_drained", qb.size(), 0);
    chk("t4_b_count", int'(b_count), 0);

    // FIFO full and overflow
    a_out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_a(32'(128 * k), 1'b1, k);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_count_full", int'(a_count), 8);
    chk("t5_no_ovf_yet", int'(a_overflow), 0);
    send_a(32'd1152, 1'b0, 0);
    send_a(32'd1280, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_count_still", int'(a_count), 8);
    chk("t5_ovf", int'(a_overflow), 1);
    a_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_empty_valid", int'(a_out_valid), 0);
    chk("t5_empty_count", int'(a_count), 0);
    chk("t5_drained", qa.size(), 0);
    a_clear = 1'b1;
    @(posedge clk);
    #1 a_clear = 1'b0;
    chk("t5_ovf_cleared", int'(a_overflow), 0);

    // Full with concurrent pop
    a_out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_a(32'(128 * k), 1'b1, k);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_count_full", int'(a_count), 8);
    send_a(32'd12800, 1'b1, 100);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    chk("t6_count", int'(a_count), 8);
    chk("t6_ovf", int'(a_overflow), 0);
    a_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_empty_count", int'(a_count), 0);
    chk("t6_drained", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
